// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its operand feeder.
//   feeder_state_t : feeder control phases
//   feed_last()    : final value of the feed counter for an N x N array
//   mat_lsb()      : LSB of element [row][col] in a row-major flattened matrix
//   lane_lsb()     : LSB of lane/element <idx> in a flattened vector
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } feeder_state_t;

  // Operand A[i][k] enters at t = i + k and meets B[k][j] at PE(i,j) at
  // t = i + j + k; the last meeting (i = j = k = N-1) happens at 3N-3.
  function automatic int feed_last(input int n);
    return 3 * n - 3;
  endfunction

  function automatic int mat_lsb(input int row, input int col, input int n, input int dw);
    return (row * n + col) * dw;
  endfunction

  function automatic int lane_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Bundle between the matrix load logic (master) and the operand feeder (slave).
//   start/stall           : run request and streaming freeze
//   a_mat_flat/b_mat_flat : row-major A[i][k] and B[k][j]
//   in_left_flat/in_top_flat, acc_rst, acc_en, shift_en : array edge drive
//   busy/done             : run status
interface systolic_feeder_if #(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
);
  logic                                      start;
  logic                                      stall;
  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] a_mat_flat;
  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] b_mat_flat;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0]         in_left_flat;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0]         in_top_flat;
  logic                                      acc_rst;
  logic                                      acc_en;
  logic                                      shift_en;
  logic                                      busy;
  logic                                      done;

  modport master (
    output start, stall, a_mat_flat, b_mat_flat,
    input  in_left_flat, in_top_flat, acc_rst, acc_en, shift_en, busy, done
  );

  modport slave (
    input  start, stall, a_mat_flat, b_mat_flat,
    output in_left_flat, in_top_flat, acc_rst, acc_en, shift_en, busy, done
  );
endinterface

// File: rtl/systolic_skew_lane.sv
// Combinational skew selector for one edge lane of the systolic array.
//   vec     : N operands for this lane (a row of A or a column of B)
//   lane    : lane index; the lane's wavefront starts lane cycles late
//   t       : feed counter
//   operand : vec[t - lane] when 0 <= t - lane < N, otherwise 0
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int T_WIDTH     = 3
) (
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] vec,
  input  logic [T_WIDTH-1:0]                lane,
  input  logic [T_WIDTH-1:0]                t,
  output logic [DATA_WIDTH-1:0]             operand
);

  // Matching t against lane + k for each legal k means an out-of-range
  // offset simply matches nothing, so no index is ever computed outside vec.
  always_comb begin
    // NOTE: default first so every path assigns operand; no latch is inferred.
    operand = '0;
    for (int k = 0; k < MATRIX_SIZE; k++) begin
      if ({1'b0, t} == ({1'b0, lane} + (T_WIDTH + 1)'(k))) begin
        operand = vec[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array computing C = A x B.
// Latches A and B on start, clears the accumulators for one cycle, streams
// skewed zero-padded wavefronts for 3N-2 advancing cycles (freezable by stall),
// then pulses done while the accumulators hold C.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : systolic_feeder_if slave (handshake, matrices, array edge drive)
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  systolic_feeder_if.slave  bus
);

  localparam int N         = MATRIX_SIZE;
  localparam int VEC_W     = N * DATA_WIDTH;
  localparam int MAT_W     = N * N * DATA_WIDTH;
  localparam int FEED_LAST = feed_last(N);
  localparam int T_WIDTH   = $clog2(3 * N - 1);
  localparam logic [T_WIDTH-1:0] T_LAST = T_WIDTH'(FEED_LAST);

  feeder_state_t          state_q, state_d;
  logic [T_WIDTH-1:0]     t_q, t_d;
  logic [MAT_W-1:0]       a_q, b_q;
  logic                   latch;
  logic [N-1:0][VEC_W-1:0] b_col;
  logic [VEC_W-1:0]       left_sel, top_sel;
  logic                   feeding;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          latch   = 1'b1;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (!bus.stall) begin
          if (t_q == T_LAST) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + T_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the matrix latches carry reset too, because a reset must leave no
  // stale operands behind; sequential state uses non-blocking assignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (latch) begin
        a_q <= bus.a_mat_flat;
        b_q <= bus.b_mat_flat;
      end
    end
  end

  // Rows of A are contiguous in the flat vector; columns of B are gathered.
  always_comb begin
    b_col = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        b_col[j][lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
          b_q[mat_lsb(k, j, N, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(
      .MATRIX_SIZE (N),
      .DATA_WIDTH  (DATA_WIDTH),
      .T_WIDTH     (T_WIDTH)
    ) u_left (
      .vec     (a_q[i*VEC_W +: VEC_W]),
      .lane    (T_WIDTH'(i)),
      .t       (t_q),
      .operand (left_sel[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );

    systolic_skew_lane #(
      .MATRIX_SIZE (N),
      .DATA_WIDTH  (DATA_WIDTH),
      .T_WIDTH     (T_WIDTH)
    ) u_top (
      .vec     (b_col[i]),
      .lane    (T_WIDTH'(i)),
      .t       (t_q),
      .operand (top_sel[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  // Outputs decode from registered state; while stalled t holds, so the
  // lanes hold as well and only the enables drop.
  assign feeding          = (state_q == FEED);
  assign bus.acc_rst      = (state_q == CLEAR);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.shift_en     = feeding && !bus.stall;
  assign bus.acc_en       = feeding && !bus.stall;
  assign bus.in_left_flat = feeding ? left_sel : '0;
  assign bus.in_top_flat  = feeding ? top_sel  : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=3, 8-bit operands).
// The reference model derives each cycle's expected outputs from the run
// schedule (one clear cycle, 3N-2 advancing feed steps, one done cycle) and
// the skew rule, and checks the streamed lanes produce A x B under the array
// contract (left operand reaches PE(i,j) j shifts later, top one i later).
module tb_systolic_feeder;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int FL   = 3 * N - 3;
  localparam int W2   = DW * N * N;
  localparam int LW   = DW * N;
  localparam int HMAX = 64;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  systolic_feeder_if #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) bus ();

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [4:0]      ctrl;
  logic [2*LW-1:0] lanes;
  assign ctrl  = {bus.busy, bus.done, bus.acc_rst, bus.shift_en, bus.acc_en};
  assign lanes = {bus.in_left_flat, bus.in_top_flat};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int el(input logic [W2-1:0] m, input int r, input int c);
    return int'(m[(r*N+c)*DW +: DW]);
  endfunction

  function automatic logic [W2-1:0] rand_mat();
    logic [W2-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = 8'($urandom);
    return m;
  endfunction

  // One complete run, entered #1 after a rising edge with the DUT in IDLE.
  task automatic run_one(input logic [W2-1:0] a, input logic [W2-1:0] b,
                         input int stall_at, input int stall_len, input bit rnd,
                         input bit hold, input bit smash);
    int adv, stalled, done_cyc, sc, acc, ref_c;
    bit in_feed, is_clear, is_done, finished, en;
    logic [LW-1:0] lh [HMAX];
    logic [LW-1:0] th [HMAX];
    logic [LW-1:0] exp_l, exp_t;

    bus.a_mat_flat = a;
    bus.b_mat_flat = b;
    bus.start      = 1'b1;
    bus.stall      = 1'b0;
    @(negedge clk);
    check("idle_ctrl", 64'(ctrl), 64'd0);
    check("idle_lanes", 64'(lanes), 64'd0);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    if (smash) bus.a_mat_flat = '1;

    adv = 0; stalled = 0; done_cyc = -1; sc = 0; finished = 1'b0;
    for (int cyc = 1; cyc < MAXC && !finished; cyc++) begin
      is_clear = (cyc == 1);
      in_feed  = !is_clear && adv <= FL;
      is_done  = !is_clear && adv > FL;
      if (rnd) begin
        if (in_feed) bus.stall = ($urandom_range(0, 3) == 0);
        else         bus.stall = ($urandom_range(0, 1) == 1);
      end else begin
        bus.stall = in_feed && adv == stall_at && stalled < stall_len;
      end
      exp_l = '0;
      exp_t = '0;
      if (in_feed) begin
        for (int i = 0; i < N; i++) begin
          if (adv - i >= 0 && adv - i < N) begin
            exp_l[i*DW +: DW] = 8'(el(a, i, adv - i));
            exp_t[i*DW +: DW] = 8'(el(b, adv - i, i));
          end
        end
      end
      en = in_feed && !bus.stall;
      @(negedge clk);
      check("ctrl", 64'(ctrl), 64'({1'b1, is_done, is_clear, en, en}));
      check("left", 64'(bus.in_left_flat), 64'(exp_l));
      check("top", 64'(bus.in_top_flat), 64'(exp_t));
      if (bus.shift_en && bus.acc_en && sc < HMAX) begin
        lh[sc] = bus.in_left_flat;
        th[sc] = bus.in_top_flat;
        sc++;
      end
      if (bus.done) done_cyc = cyc;
      @(posedge clk); #1;
      if (in_feed) begin
        if (bus.stall) stalled++;
        else           adv++;
      end
      if (is_done) finished = 1'b1;
    end
    bus.stall = 1'b0;
    check("done_cycle", 64'(done_cyc), 64'(3 * N + stalled));

    // Accumulate what the array would see from the streamed lanes.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int s = 0; s < sc; s++) begin
          if (s - j >= 0 && s - i >= 0)
            acc += int'(lh[s-j][i*DW +: DW]) * int'(th[s-i][j*DW +: DW]);
        end
        ref_c = 0;
        for (int k = 0; k < N; k++) ref_c += el(a, i, k) * el(b, k, j);
        check($sformatf("c[%0d][%0d]", i, j), 64'(acc), 64'(ref_c));
      end
    end
  endtask

  logic [W2-1:0] a_id, b_seq;

  initial begin
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.a_mat_flat = '0;
    bus.b_mat_flat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_id[(r*N+c)*DW +: DW]  = (r == c) ? 8'd1 : 8'd0;
        b_seq[(r*N+c)*DW +: DW] = 8'(r * N + c + 1);
      end
    end

    #1;
    check("reset_ctrl", 64'(ctrl), 64'd0);
    check("reset_lanes", 64'(lanes), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Identity x sequential, no stall; then same with a 3-cycle stall at t=4.
    run_one(a_id, b_seq, -1, 0, 1'b0, 1'b0, 1'b0);
    run_one(a_id, b_seq, 4, 3, 1'b0, 1'b0, 1'b0);

    // Random matrices with random stall patterns.
    for (int r = 0; r < 6; r++) run_one(rand_mat(), rand_mat(), -1, 0, 1'b1, 1'b0, 1'b0);

    // Start held through a whole run; the IDLE-cycle start launches run two.
    run_one(rand_mat(), rand_mat(), -1, 0, 1'b0, 1'b1, 1'b0);
    run_one(rand_mat(), rand_mat(), 0, 2, 1'b0, 1'b0, 1'b0);

    // A driven to all ones after the start edge must not affect the run.
    run_one(rand_mat(), rand_mat(), FL, 1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in cycle 5 (mid-feed).
    bus.a_mat_flat = rand_mat();
    bus.b_mat_flat = rand_mat();
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_ctrl", 64'(ctrl), 64'd0);
    check("rst_async_lanes", 64'(lanes), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_ctrl", 64'(ctrl), 64'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 64'(ctrl), 64'd0);
    end
    @(posedge clk); #1;
    run_one(rand_mat(), rand_mat(), -1, 0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    check("final_idle", 64'(ctrl), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
